pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RV32 pipeline. It generates every stall, bubble and flush control for the pipeline registers: load-use interlock, taken-branch squash, data-memory wait with timeout, and start/stall/done sequencing of the iterative multiply/divide unit (MDU) in EX. It sits beside the forwarding unit. Its outputs drive the PC enable and the IF/ID, ID/EX, EX/MEM and MEM/WB register controls.

## Interface
- MDU_LAT, 32, MDU cycles from MduStart to result valid; legal range ≥2
- MEM_TIMEOUT, 256, maximum consecutive data-memory wait cycles before abort; legal range ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rs1Addr_id, rs2Addr_id  in  5 each  source registers of the instruction in ID
- MemRead_ex  in  1  EX instruction is a load
- rdAddr_ex  in  5  destination of the EX instruction
- MduOp_ex  in  1  EX instruction is MUL/DIV/REM
- BranchTaken_ex  in  1  EX resolved a taken branch or jump
- DmemReq_mem, DmemReady_mem  in  1 each  data-memory request from MEM / memory ready
- Stall_if  out  1  hold PC
- Stall_id  out  1  hold IF/ID
- Stall_ex  out  1  hold ID/EX
- Stall_mem  out  1  hold EX/MEM
- Flush_id  out  1  load NOP into IF/ID
- Bubble_ex  out  1  load NOP into ID/EX
- Bubble_mem  out  1  load NOP into EX/MEM
- Bubble_wb  out  1  load NOP into MEM/WB
- MduStart  out  1  one-cycle start to MDU
- MduDone  out  1  MDU result valid this cycle; EX advances
- MduBusy  out  1  state is BUSY
- MemFault  out  1  one-cycle pulse: memory access aborted by timeout

## Operation
- State machine has two states: RUN and BUSY.
- Registers:
  - mdu_cnt, width $clog2(MDU_LAT)
  - wait_cnt, width $clog2(MEM_TIMEOUT)
- Derived terms:
  - mem_wait = DmemReq_mem & !DmemReady_mem
  - timeout_hit = mem_wait & (wait_cnt == MEM_TIMEOUT-1)
  - MemStall = mem_wait & !timeout_hit
  - MduStall = (RUN & MduOp_ex) | (BUSY & mdu_cnt != 0)
  - LoadUse = MemRead_ex & rdAddr_ex != 0 & (rdAddr_ex == rs1Addr_id | rdAddr_ex == rs2Addr_id)
- Strict priority; every output not listed for the winning case is 0:
  1. MemStall: Stall_if = Stall_id = Stall_ex = Stall_mem = 1 and Bubble_wb = 1.
  2. MduStall: Stall_if = Stall_id = Stall_ex = 1 and Bubble_mem = 1. MduStart = 1 only when in RUN.
  3. BranchTaken_ex: Flush_id = 1, Bubble_ex = 1.
  4. LoadUse: Stall_if = Stall_id = 1, Bubble_ex = 1.
- Outputs outside this priority:
  - MduDone = BUSY & mdu_cnt == 0 & !MemStall.
  - MemFault = timeout_hit.
  - MduBusy = BUSY.
- Transitions:
  - RUN→BUSY on MduStart; mdu_cnt ← MDU_LAT-1.
  - In BUSY, each cycle with !MemStall and mdu_cnt ≠ 0: mdu_cnt decrements.
  - BUSY→RUN on MduDone.
  - MemStall freezes mdu_cnt and the state.
- wait_cnt:
  - Increments when MemStall.
  - Clears when !mem_wait or timeout_hit.
- On timeout, the stall releases in the timeout_hit cycle. The MEM instruction advances and trap logic consumes MemFault.
- Branch and load-use are deferred (not lost) under any stall, because EX and ID contents are held.

## Timing
- All stall, bubble and flush outputs, plus MduStart and MemFault, are combinational from state, counters and current inputs. They are consumed at the next rising edge.
- While rst_n = 0: state = RUN, both counters = 0, and every output is forced to 0 regardless of inputs.
- Reset asserted mid-MDU or mid-wait aborts immediately; after release the controller is in RUN with no pending pulse.
- MDU latency:
  - MduDone is asserted exactly MDU_LAT cycles after MduStart when no MemStall intervenes; each MemStall cycle adds one cycle.
  - EX is held for MDU_LAT cycles in total.
  - MduStart is never reasserted for the same instruction: in the MduDone cycle the state is BUSY, so no start is issued.
- Back-to-back MDU ops: the second starts in the cycle after MduDone.
- Memory:
  - An access ready in its first cycle produces no stall.
  - A never-ready access stalls for MEM_TIMEOUT-1 cycles and pulses MemFault in cycle MEM_TIMEOUT of the wait.
- Branch squash plus load-use in the same cycle: the branch wins, with no Stall_if/Stall_id.

## Test plan
- Load-use: lw x5 in EX (MemRead_ex=1, rdAddr_ex=5) with rs2Addr_id=5 → exactly one cycle of Stall_if=Stall_id=Bubble_ex=1. Repeat with rdAddr_ex=0 → no stall.
- MDU, MDU_LAT=4: MduOp_ex held from cycle 0 → MduStart at cycle 0, stalls in cycles 0–3, MduDone and zero stall at cycle 4, MduBusy high in cycles 1–4.
- Memory wait: DmemReady_mem low for 3 cycles then high → a 3-cycle full freeze with Bubble_wb=1, wait_cnt back to 0, no MemFault. With MEM_TIMEOUT=8 and never ready → 7 stall cycles, MemFault pulse on the 8th with stalls released.
- Overlap: MemStall starts during BUSY with mdu_cnt=2 for 5 cycles → counter frozen; MduDone occurs 5 cycles later than the undisturbed case; MduStart is not re-issued.
- Priority: BranchTaken_ex and LoadUse together → Flush_id=Bubble_ex=1, Stall_if=0. BranchTaken_ex under MemStall → flush appears in the first cycle after ready.
- Reset: drop rst_n during BUSY (mdu_cnt=10) and during a memory wait → all outputs 0 immediately; after release, MduOp_ex=1 gives a fresh MduStart in the first clock.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: stalls, bubbles, flushes, MDU sequencing, memory-wait timeout.
// Controls are combinational from state, counters and current inputs; they are consumed at the next rising edge.
module pipeline_ctrl #(
  parameter int MDU_LAT     = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1Addr_id,
  input  logic [4:0] rs2Addr_id,
  input  logic       MemRead_ex,
  input  logic [4:0] rdAddr_ex,
  input  logic       MduOp_ex,
  input  logic       BranchTaken_ex,
  input  logic       DmemReq_mem,
  input  logic       DmemReady_mem,
  output logic       Stall_if,
  output logic       Stall_id,
  output logic       Stall_ex,
  output logic       Stall_mem,
  output logic       Flush_id,
  output logic       Bubble_ex,
  output logic       Bubble_mem,
  output logic       Bubble_wb,
  output logic       MduStart,
  output logic       MduDone,
  output logic       MduBusy,
  output logic       MemFault
);

  localparam int MCW = $clog2(MDU_LAT);
  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [MCW-1:0] MDU_LOAD  = MCW'(MDU_LAT - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } ctrlState_t;

  ctrlState_t     state;
  logic [MCW-1:0] mduCnt;
  logic [WCW-1:0] waitCnt;

  logic memWait;
  logic timeoutHit;
  logic memStall;
  logic mduStall;
  logic loadUse;
  logic mduDoneRaw;

  always_comb begin
    memWait    = DmemReq_mem & ~DmemReady_mem;
    timeoutHit = memWait & (waitCnt == WAIT_LAST);
    memStall   = memWait & ~timeoutHit;
    mduStall   = ((state == RUN) & MduOp_ex) | ((state == BUSY) & (mduCnt != '0));
    loadUse    = MemRead_ex & (rdAddr_ex != 5'd0) &
                 ((rdAddr_ex == rs1Addr_id) | (rdAddr_ex == rs2Addr_id));
    mduDoneRaw = (state == BUSY) & (mduCnt == '0) & ~memStall;
  end

  // Reset gates every output so nothing leaks out while rst_n is low.
  always_comb begin
    Stall_if   = 1'b0;
    Stall_id   = 1'b0;
    Stall_ex   = 1'b0;
    Stall_mem  = 1'b0;
    Flush_id   = 1'b0;
    Bubble_ex  = 1'b0;
    Bubble_mem = 1'b0;
    Bubble_wb  = 1'b0;
    MduStart   = 1'b0;
    MduDone    = 1'b0;
    MduBusy    = 1'b0;
    MemFault   = 1'b0;
    if (rst_n) begin
      if (memStall) begin
        Stall_if  = 1'b1;
        Stall_id  = 1'b1;
        Stall_ex  = 1'b1;
        Stall_mem = 1'b1;
        Bubble_wb = 1'b1;
      end else if (mduStall) begin
        Stall_if   = 1'b1;
        Stall_id   = 1'b1;
        Stall_ex   = 1'b1;
        Bubble_mem = 1'b1;
        MduStart   = (state == RUN);
      end else if (BranchTaken_ex) begin
        Flush_id  = 1'b1;
        Bubble_ex = 1'b1;
      end else if (loadUse) begin
        Stall_if  = 1'b1;
        Stall_id  = 1'b1;
        Bubble_ex = 1'b1;
      end
      MduDone  = mduDoneRaw;
      MduBusy  = (state == BUSY);
      MemFault = timeoutHit;
    end
  end

  // A memory stall freezes the MDU sequencer so EX and the MDU stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mduCnt  <= '0;
      waitCnt <= '0;
    end else begin
      waitCnt <= memStall ? (waitCnt + WCW'(1)) : '0;
      if (!memStall) begin
        case (state)
          RUN: begin
            if (MduOp_ex) begin
              state  <= BUSY;
              mduCnt <= MDU_LOAD;
            end
          end
          BUSY: begin
            if (mduCnt != '0) begin
              mduCnt <= mduCnt - MCW'(1);
            end else begin
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) MduStart |-> !MduBusy);
  assert property (@(posedge clk) disable iff (!rst_n) Stall_mem |-> (Stall_ex && !MduStart));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl with MDU_LAT=4, MEM_TIMEOUT=8: expected control vectors queued per driven cycle, checked mid-cycle.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] rs1, rs2, rdEx;
  logic       memRead, mduOp, brTaken, dReq, dRdy;

  logic sIf, sId, sEx, sMem, fId, bEx, bMem, bWb, mStart, mDone, mBusy, mFault;
  logic [11:0] obs;

  // Vector order: Stall_if Stall_id Stall_ex Stall_mem | Flush_id Bubble_ex Bubble_mem Bubble_wb | MduStart MduDone MduBusy MemFault
  localparam logic [11:0] E_NONE  = 12'b0000_0000_0000;
  localparam logic [11:0] E_LU    = 12'b1100_0100_0000;
  localparam logic [11:0] E_BR    = 12'b0000_1100_0000;
  localparam logic [11:0] E_MS    = 12'b1111_0001_0000;
  localparam logic [11:0] E_MDS   = 12'b1110_0010_0000;
  localparam logic [11:0] E_START = 12'b1110_0010_1000;
  localparam logic [11:0] E_BUSY  = 12'b0000_0000_0010;
  localparam logic [11:0] E_DONE  = 12'b0000_0000_0110;
  localparam logic [11:0] E_FAULT = 12'b0000_0000_0001;

  int nCompared = 0;
  int nMismatch = 0;

  logic [11:0] expQ[$];
  string       tagQ[$];
  logic [11:0] monExp;
  string       monTag;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MDU_LAT(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rstN),
    .rs1Addr_id(rs1), .rs2Addr_id(rs2),
    .MemRead_ex(memRead), .rdAddr_ex(rdEx),
    .MduOp_ex(mduOp), .BranchTaken_ex(brTaken),
    .DmemReq_mem(dReq), .DmemReady_mem(dRdy),
    .Stall_if(sIf), .Stall_id(sId), .Stall_ex(sEx), .Stall_mem(sMem),
    .Flush_id(fId), .Bubble_ex(bEx), .Bubble_mem(bMem), .Bubble_wb(bWb),
    .MduStart(mStart), .MduDone(mDone), .MduBusy(mBusy), .MemFault(mFault)
  );

  assign obs = {sIf, sId, sEx, sMem, fId, bEx, bMem, bWb, mStart, mDone, mBusy, mFault};

  task automatic checkEq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monExp = expQ.pop_front();
      monTag = tagQ.pop_front();
      checkEq(monTag, obs, monExp);
    end
  end

  // Inputs are already set for this cycle; queue what the controller must show, then advance.
  task automatic cyc(input string tag, input logic [11:0] exp);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1 = 5'd0; rs2 = 5'd0; rdEx = 5'd0;
    memRead = 1'b0; mduOp = 1'b0; brTaken = 1'b0;
    dReq = 1'b0; dRdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // Reset: all outputs low no matter how hostile the inputs are.
    memRead = 1'b1; rdEx = 5'd5; rs1 = 5'd5; mduOp = 1'b1; brTaken = 1'b1; dReq = 1'b1;
    cyc("rst_hold0", E_NONE);
    cyc("rst_hold1", E_NONE);
    clr();
    rstN = 1'b1;
    cyc("rst_release", E_NONE);

    // Load-use interlock.
    memRead = 1'b1; rdEx = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    cyc("lu_rs2", E_LU);
    clr();
    cyc("lu_after", E_NONE);
    memRead = 1'b1; rdEx = 5'd7; rs1 = 5'd7; rs2 = 5'd1;
    cyc("lu_rs1", E_LU);
    memRead = 1'b1; rdEx = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    cyc("lu_x0", E_NONE);
    memRead = 1'b1; rdEx = 5'd5; rs1 = 5'd6; rs2 = 5'd7;
    cyc("lu_nomatch", E_NONE);
    memRead = 1'b0; rdEx = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
    cyc("lu_notload", E_NONE);

    // Branch beats load-use; branch alone.
    memRead = 1'b1; rdEx = 5'd5; rs1 = 5'd5; brTaken = 1'b1;
    cyc("br_over_lu", E_BR);
    clr(); brTaken = 1'b1;
    cyc("br_alone", E_BR);
    clr();

    // MDU, then a back-to-back second op.
    mduOp = 1'b1;
    cyc("mdu_start", E_START);
    for (int i = 0; i < 3; i++) cyc("mdu_busy", E_MDS | E_BUSY);
    cyc("mdu_done", E_DONE);
    cyc("mdu2_start", E_START);
    for (int i = 0; i < 3; i++) cyc("mdu2_busy", E_MDS | E_BUSY);
    cyc("mdu2_done", E_DONE);
    clr();
    cyc("mdu_idle", E_NONE);

    // Memory: ready first cycle, short wait, then full timeout.
    dReq = 1'b1; dRdy = 1'b1;
    cyc("mem_ready", E_NONE);
    dRdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mem_wait3", E_MS);
    dRdy = 1'b1;
    cyc("mem_wait3_rdy", E_NONE);
    dRdy = 1'b0;
    for (int i = 0; i < 7; i++) cyc("mem_to_stall", E_MS);
    cyc("mem_to_fault", E_FAULT);
    cyc("mem_to_next", E_MS);
    clr();
    cyc("mem_idle", E_NONE);

    // Memory stall lands in BUSY with mdu_cnt=2: counter freezes for 5 cycles.
    mduOp = 1'b1;
    cyc("ovl_start", E_START);
    cyc("ovl_busy3", E_MDS | E_BUSY);
    dReq = 1'b1; dRdy = 1'b0;
    for (int i = 0; i < 5; i++) cyc("ovl_frozen", E_MS | E_BUSY);
    dRdy = 1'b1;
    cyc("ovl_busy2", E_MDS | E_BUSY);
    cyc("ovl_busy1", E_MDS | E_BUSY);
    cyc("ovl_done", E_DONE);
    clr();
    cyc("ovl_idle", E_NONE);

    // Branch and MDU start deferred by a memory stall.
    brTaken = 1'b1; dReq = 1'b1; dRdy = 1'b0;
    cyc("br_ms0", E_MS);
    cyc("br_ms1", E_MS);
    dRdy = 1'b1;
    cyc("br_after_ms", E_BR);
    clr();
    mduOp = 1'b1; dReq = 1'b1; dRdy = 1'b0;
    cyc("mdu_ms", E_MS);
    dRdy = 1'b1;
    cyc("mdu_after_ms", E_START);
    for (int i = 0; i < 3; i++) cyc("mdu_after_busy", E_MDS | E_BUSY);
    cyc("mdu_after_done", E_DONE);
    clr();

    // Reset mid-MDU: immediate quiet, fresh start after release.
    mduOp = 1'b1;
    cyc("rmdu_start", E_START);
    cyc("rmdu_busy", E_MDS | E_BUSY);
    rstN = 1'b0;
    cyc("rmdu_rst0", E_NONE);
    cyc("rmdu_rst1", E_NONE);
    rstN = 1'b1;
    cyc("rmdu_restart", E_START);
    for (int i = 0; i < 3; i++) cyc("rmdu_busy2", E_MDS | E_BUSY);
    cyc("rmdu_done", E_DONE);
    clr();

    // Reset mid-wait: the wait counter restarts from zero afterwards.
    dReq = 1'b1; dRdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc("rmem_wait", E_MS);
    rstN = 1'b0;
    cyc("rmem_rst", E_NONE);
    rstN = 1'b1;
    for (int i = 0; i < 7; i++) cyc("rmem_stall", E_MS);
    cyc("rmem_fault", E_FAULT);
    clr();
    cyc("final_idle", E_NONE);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
